// File: rtl/ps2_key_ctrl_pkg.sv
// Shared constants, fetch-state encoding and event record for the PS/2 key
// controller and its helpers.
package ps2_key_ctrl_pkg;

   localparam logic [7:0] PFX_E0 = 8'hE0;
   localparam logic [7:0] PFX_F0 = 8'hF0;
   localparam logic [7:0] PFX_E1 = 8'hE1;

   localparam logic [7:0] DSC_00 = 8'h00;
   localparam logic [7:0] DSC_AA = 8'hAA;
   localparam logic [7:0] DSC_FA = 8'hFA;
   localparam logic [7:0] DSC_FE = 8'hFE;
   localparam logic [7:0] DSC_FF = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_POP  = 2'd1,
      ST_GAP  = 2'd2
   } fetch_st_e;

   typedef struct packed {
      logic [7:0] code;
      logic       ext;
      logic       brk;
      logic       rep;
   } key_evt_t;

   // Keyboard status/ack bytes that carry no key information.
   function automatic logic is_discard(input logic [7:0] b);
      return (b == DSC_00) || (b == DSC_AA) || (b == DSC_FA) ||
             (b == DSC_FE) || (b == DSC_FF);
   endfunction

endpackage

// File: rtl/ps2_key_ctrl_if.sv
// Bundle between the FIFO/consumer side and the key controller.
// Handshake: an event transfers on any clock edge where evt_valid && evt_ready;
// evt_valid never drops and the event fields never change until that edge.
interface ps2_key_ctrl_if;
   import ps2_key_ctrl_pkg::*;

   logic [7:0] kb_data;
   logic       kb_ready;
   logic       kb_overflow;
   logic       nextdata_n;
   logic       evt_valid;
   logic       evt_ready;
   logic [7:0] evt_code;
   logic       evt_ext;
   logic       evt_brk;
   logic       evt_rep;
   logic [7:0] press_bcd;
   logic       ovf_sticky;
   logic       clr_stat;
   fetch_st_e  fetch_state;

   modport master (
      input  kb_data, kb_ready, kb_overflow, evt_ready, clr_stat,
      output nextdata_n, evt_valid, evt_code, evt_ext, evt_brk, evt_rep,
             press_bcd, ovf_sticky, fetch_state
   );

   modport slave (
      output kb_data, kb_ready, kb_overflow, evt_ready, clr_stat,
      input  nextdata_n, evt_valid, evt_code, evt_ext, evt_brk, evt_rep,
             press_bcd, ovf_sticky, fetch_state
   );
endinterface

// File: rtl/ps2_key_ctrl_bcd_sat99.sv
// Two-digit BCD press counter: increments, holds at 99, clear wins over increment.
module bcd_sat99 (
   input  logic       clk,
   input  logic       rstn,
   input  logic       i_inc,
   input  logic       i_clr,
   output logic [7:0] o_bcd
);
   logic [7:0] r_bcd;

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_bcd <= 8'h00;
      end else if (i_clr) begin
         r_bcd <= 8'h00;
      end else if (i_inc && (r_bcd != 8'h99)) begin
         if (r_bcd[3:0] == 4'd9) begin
            r_bcd <= {r_bcd[7:4] + 4'd1, 4'd0};
         end else begin
            r_bcd <= {r_bcd[7:4], r_bcd[3:0] + 4'd1};
         end
      end
   end

   assign o_bcd = r_bcd;
endmodule

// File: rtl/ps2_key_ctrl.sv
// Pops scan-code bytes from the ps2_key FIFO, folds E0/F0/E1 prefixes into
// one key event per transition, tracks the held key and keeps press stats.
module ps2_key_ctrl
   import ps2_key_ctrl_pkg::*;
#(
   parameter int REPEAT_EMIT = 1,
   parameter int E1_SKIP     = 7
) (
   input  logic           clk,
   input  logic           rstn,
   ps2_key_ctrl_if.master bus
);
   fetch_st_e  r_state;
   logic [7:0] r_byte;
   logic       r_nextdata_n;
   logic       r_evt_valid;
   key_evt_t   r_evt;
   logic       r_ext;
   logic       r_brk;
   logic [7:0] r_skip;
   logic       r_held_v;
   logic [7:0] r_held_code;
   logic       r_held_ext;
   logic       r_ovf;

   logic       w_slot_free;
   logic       w_pfx;
   logic       w_discard;
   logic       w_final;
   logic       w_match;
   logic       w_inc;
   logic       w_emit;
   logic [7:0] w_bcd;

   assign w_slot_free = !r_evt_valid || bus.evt_ready;
   assign w_pfx       = (r_byte == PFX_E0) || (r_byte == PFX_F0) || (r_byte == PFX_E1);
   assign w_discard   = is_discard(r_byte) && !r_ext && !r_brk;
   assign w_final     = (r_state == ST_POP) && (r_skip == 8'd0) && !w_pfx && !w_discard;
   assign w_match     = r_held_v && (r_held_code == r_byte) && (r_held_ext == r_ext);
   assign w_inc       = w_final && !r_brk && !w_match;
   assign w_emit      = w_final && (r_brk || !w_match || (REPEAT_EMIT != 0));

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_state      <= ST_IDLE;
         r_byte       <= 8'h00;
         r_nextdata_n <= 1'b1;
         r_evt_valid  <= 1'b0;
         r_evt        <= '0;
         r_ext        <= 1'b0;
         r_brk        <= 1'b0;
         r_skip       <= 8'd0;
         r_held_v     <= 1'b0;
         r_held_code  <= 8'h00;
         r_held_ext   <= 1'b0;
         r_ovf        <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (bus.kb_ready && w_slot_free) begin
                  r_byte       <= bus.kb_data;
                  r_nextdata_n <= 1'b0;
                  r_state      <= ST_POP;
               end
            end
            ST_POP: begin
               r_nextdata_n <= 1'b1;
               r_state      <= ST_GAP;
               if (r_skip != 8'd0) begin
                  r_skip <= r_skip - 8'd1;
               end else if (r_byte == PFX_E1) begin
                  r_skip <= 8'(E1_SKIP);
                  r_ext  <= 1'b0;
                  r_brk  <= 1'b0;
               end else if (r_byte == PFX_E0) begin
                  r_ext <= 1'b1;
               end else if (r_byte == PFX_F0) begin
                  r_brk <= 1'b1;
               end else if (w_final) begin
                  r_ext <= 1'b0;
                  r_brk <= 1'b0;
                  if (r_brk) begin
                     if (w_match) r_held_v <= 1'b0;
                  end else if (!w_match) begin
                     r_held_v    <= 1'b1;
                     r_held_code <= r_byte;
                     r_held_ext  <= r_ext;
                  end
               end
            end
            // GAP gives the FIFO one cycle to advance before kb_ready is trusted.
            default: begin
               r_nextdata_n <= 1'b1;
               r_state      <= ST_IDLE;
            end
         endcase

         if (w_emit) begin
            r_evt_valid <= 1'b1;
            r_evt.code  <= r_byte;
            r_evt.ext   <= r_ext;
            r_evt.brk   <= r_brk;
            r_evt.rep   <= w_match && !r_brk;
         end else if (r_evt_valid && bus.evt_ready) begin
            r_evt_valid <= 1'b0;
         end

         r_ovf <= bus.clr_stat ? 1'b0 : (r_ovf | bus.kb_overflow);
      end
   end

   bcd_sat99 u_bcd (
      .clk   (clk),
      .rstn  (rstn),
      .i_inc (w_inc),
      .i_clr (bus.clr_stat),
      .o_bcd (w_bcd)
   );

   assign bus.nextdata_n  = r_nextdata_n;
   assign bus.evt_valid   = r_evt_valid;
   assign bus.evt_code    = r_evt.code;
   assign bus.evt_ext     = r_evt.ext;
   assign bus.evt_brk     = r_evt.brk;
   assign bus.evt_rep     = r_evt.rep;
   assign bus.press_bcd   = w_bcd;
   assign bus.ovf_sticky  = r_ovf;
   assign bus.fetch_state = r_state;
endmodule
